spi_frame_tx: RTL



---
 rtl/spi_frame_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_frame_tx.sv
// Frame serialiser toward the RP2350 SPI master: one-deep holding buffer, status header
// {fresh, drop, seq[5:0]} followed by NUM_CH channel words, SCK/CS oversampled on clk.
module spi_frame_tx #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 1,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] frame_data,
  input  logic                     frame_valid,
  input  logic                     rpi_sck,
  input  logic                     rpi_cs,
  output logic                     rpi_miso,
  output logic                     busy,
  output logic                     drop_pulse
);

  localparam int PAY_W   = NUM_CH * DATA_W;
  localparam int FRAME_W = 8 + PAY_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  state_t               state_q, state_d;
  logic                 sck_p0, sck_p1, sck_p2;
  logic                 cs_p0, cs_p1, cs_p2;
  logic                 lead, trail, cs_fall, cs_rise;
  logic [PAY_W-1:0]     hold_q, last_q;
  logic [5:0]           hold_seq_q, last_seq_q, seq_q;
  logic                 hold_full_q, drop_flag_q;
  logic [FRAME_W-1:0]   shift_reg_q, load_frame;
  logic [CNT_W-1:0]     bit_cnt_q, cnt_d;
  logic                 load, shift_en, miso_d, fresh_load, drop_evt;

  // Synchroniser stages; CS flops reset low so a CS already low at reset release
  // produces no falling edge until it has been seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_p0 <= CPOL;
      sck_p1 <= CPOL;
      sck_p2 <= CPOL;
      cs_p0  <= 1'b0;
      cs_p1  <= 1'b0;
      cs_p2  <= 1'b0;
    end else begin
      sck_p0 <= rpi_sck;
      sck_p1 <= sck_p0;
      sck_p2 <= sck_p1;
      cs_p0  <= rpi_cs;
      cs_p1  <= cs_p0;
      cs_p2  <= cs_p1;
    end
  end

  assign lead    = (sck_p1 ^ CPOL) & ~(sck_p2 ^ CPOL);
  assign trail   = ~(sck_p1 ^ CPOL) & (sck_p2 ^ CPOL);
  assign cs_fall = ~cs_p1 & cs_p2;
  assign cs_rise = cs_p1 & ~cs_p2;

  assign load_frame = hold_full_q ? {1'b1, drop_flag_q, hold_seq_q, hold_q}
                                  : {1'b0, drop_flag_q, last_seq_q, last_q};
  assign fresh_load = load & hold_full_q;
  // A frame arriving in a fresh-load cycle lands in a buffer that is being emptied.
  assign drop_evt   = frame_valid & hold_full_q & ~fresh_load;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    miso_d   = rpi_miso;
    cnt_d    = bit_cnt_q;
    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (cs_fall) begin
          state_d = SHIFT;
          load    = 1'b1;
          cnt_d   = '0;
          if (!CPHA) miso_d = load_frame[FRAME_W-1];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b1;
        end else if (!CPHA && trail) begin
          shift_en = 1'b1;
          cnt_d    = bit_cnt_q + CNT_ONE;
          if (bit_cnt_q == CNT_LAST) begin
            state_d = WAIT_CS;
            miso_d  = 1'b1;
          end else begin
            miso_d = shift_reg_q[FRAME_W-2];
          end
        end else if (CPHA && lead && bit_cnt_q != CNT_FULL) begin
          shift_en = 1'b1;
          cnt_d    = bit_cnt_q + CNT_ONE;
          miso_d   = shift_reg_q[FRAME_W-1];
        end else if (CPHA && trail && bit_cnt_q == CNT_FULL) begin
          state_d = WAIT_CS;
          miso_d  = 1'b1;
        end
      end
      WAIT_CS: begin
        miso_d = 1'b1;
        if (cs_rise) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b1;
      end
    endcase
  end

  // Control and serial-output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rpi_miso    <= 1'b1;
      shift_reg_q <= '1;
      drop_pulse  <= 1'b0;
      hold_full_q <= 1'b0;
      drop_flag_q <= 1'b0;
      seq_q       <= '0;
      last_q      <= '0;
      last_seq_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= cnt_d;
      rpi_miso    <= miso_d;
      drop_pulse  <= drop_evt;
      hold_full_q <= frame_valid | (hold_full_q & ~fresh_load);
      drop_flag_q <= drop_evt | (drop_flag_q & ~fresh_load);
      if (frame_valid) seq_q <= seq_q + 6'd1;
      if (load) shift_reg_q <= load_frame;
      else if (shift_en) shift_reg_q <= {shift_reg_q[FRAME_W-2:0], 1'b1};
      if (fresh_load) begin
        last_q     <= hold_q;
        last_seq_q <= hold_seq_q;
      end
    end
  end

  // Holding-buffer data stage; contents are qualified by hold_full_q
  always_ff @(posedge clk) begin
    if (frame_valid) begin
      hold_q     <= frame_data;
      hold_seq_q <= seq_q;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
